ccu2_mp_sequencer: RTL and testbench

//   Arbitrated multi-precision add/sub sequencer for the CCU2C carry-chain datapath.
//   Two requesters share one LIMB_W-bit carry chain; the block arbitrates round-robin and streams

---
 rtl/ccu2_seq_pkg.sv | 16 +
 rtl/ccu2_limb_adder.sv | 26 ++
 rtl/ccu2_mp_sequencer.sv | 140 ++++++++++++++
 tb/tb_ccu2_mp_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu2_seq_pkg.sv
// Shared types and defaults for the CCU2C multi-precision add/sub sequencer.
package ccu2_seq_pkg;

  localparam int unsigned LIMB_W_DEF = 8;
  localparam int unsigned LIMBS_DEF  = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ccu2_limb_adder.sv
// Combinational LIMB_W-bit a+b+cin built as a ripple of 2-bit CCU2C-style slices.
// Carry enters only through i_cin (no per-slice carry injection).
module ccu2_limb_adder #(
  parameter int unsigned LIMB_W = 8
) (
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  input  logic              i_cin,
  output logic [LIMB_W-1:0] o_sum,
  output logic              o_cout
);

  localparam int unsigned Slices = LIMB_W / 2;

  logic [Slices:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar s = 0; s < Slices; s++) begin : g_slice
    assign {w_c[s+1], o_sum[2*s +: 2]} = {1'b0, i_a[2*s +: 2]} + {1'b0, i_b[2*s +: 2]}
                                         + {2'b00, w_c[s]};
  end

  assign o_cout = w_c[Slices];

endmodule

// File: rtl/ccu2_mp_sequencer.sv
// Round-robin arbitrated multi-precision add/sub, one limb per cycle LSB first.
// Optional CCU2_SEQ_FLAGS_EN adds registered RSP_ZERO / RSP_OVF result flags.
module ccu2_mp_sequencer
  import ccu2_seq_pkg::*;
#(
  parameter int unsigned LIMB_W = LIMB_W_DEF,
  parameter int unsigned LIMBS  = LIMBS_DEF
) (
  input  logic                       CLK,
  input  logic                       SRN,
  input  logic [1:0]                 REQ_VALID,
  output logic [1:0]                 REQ_READY,
  input  logic [1:0]                 REQ_SUB,
  input  logic [2*LIMB_W*LIMBS-1:0]  REQ_A,
  input  logic [2*LIMB_W*LIMBS-1:0]  REQ_B,
  output logic                       RSP_VALID,
  input  logic                       RSP_READY,
  output logic                       RSP_ID,
  output logic [LIMB_W*LIMBS-1:0]    RSP_SUM,
  output logic                       RSP_COUT,
`ifdef CCU2_SEQ_FLAGS_EN
  output logic                       RSP_ZERO,
  output logic                       RSP_OVF,
`endif
  output logic                       BUSY
);

  localparam int unsigned W       = LIMB_W * LIMBS;
  localparam int unsigned IdxW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LIMBS - 1);

  seq_state_e r_state, w_state_d;

  logic            r_last, r_sub, r_id, r_carry, r_cout;
  logic [IdxW-1:0] r_idx;
  logic [W-1:0]    r_a, r_b, r_sum;

  logic              w_gnt, w_accept, w_last_limb, w_cout;
  logic [LIMB_W-1:0] w_b_eff, w_sum_limb;
  logic [W-1:0]      w_sum_next, w_a_sel, w_b_sel;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign w_gnt       = (&REQ_VALID) ? ~r_last : REQ_VALID[1];
  assign w_accept    = (r_state == IDLE) && REQ_VALID[w_gnt];
  assign w_last_limb = (r_idx == LastIdx);
  assign w_a_sel     = w_gnt ? REQ_A[2*W-1:W] : REQ_A[W-1:0];
  assign w_b_sel     = w_gnt ? REQ_B[2*W-1:W] : REQ_B[W-1:0];
  assign w_b_eff     = (r_sub == OP_SUB) ? ~r_b[LIMB_W-1:0] : r_b[LIMB_W-1:0];

  ccu2_limb_adder #(
    .LIMB_W (LIMB_W)
  ) u_limb_adder (
    .i_a    (r_a[LIMB_W-1:0]),
    .i_b    (w_b_eff),
    .i_cin  (r_carry),
    .o_sum  (w_sum_limb),
    .o_cout (w_cout)
  );

  // New limb enters at the top so the result lands LSB-aligned after LIMBS passes.
  if (LIMBS == 1) begin : g_one_limb
    assign w_sum_next = w_sum_limb;
  end else begin : g_multi_limb
    assign w_sum_next = {w_sum_limb, r_sum[W-1:LIMB_W]};
  end

  always_comb begin
    w_state_d = r_state;
    REQ_READY = 2'b00;
    unique case (r_state)
      IDLE: begin
        REQ_READY[w_gnt] = REQ_VALID[w_gnt];
        if (REQ_VALID[w_gnt]) w_state_d = RUN;
      end
      RUN:     if (w_last_limb) w_state_d = DONE;
      DONE:    if (RSP_READY) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge SRN) begin
    if (!SRN) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  always_ff @(posedge CLK or negedge SRN) begin
    if (!SRN) begin
      r_last  <= 1'b1;
      r_sub   <= OP_ADD;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= w_a_sel;
      r_b     <= w_b_sel;
      r_sub   <= REQ_SUB[w_gnt];
      r_carry <= REQ_SUB[w_gnt];
      r_id    <= w_gnt;
      r_last  <= w_gnt;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> LIMB_W;
      r_b     <= r_b >> LIMB_W;
      r_sum   <= w_sum_next;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last_limb) r_cout <= w_cout;
    end
  end

`ifdef CCU2_SEQ_FLAGS_EN
  logic r_zero, r_ovf;

  // On the last limb r_a/w_b_eff hold the top limbs, so their msbs are the operand signs.
  always_ff @(posedge CLK or negedge SRN) begin
    if (!SRN) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == RUN) && w_last_limb) begin
      r_zero <= (w_sum_next == '0);
      r_ovf  <= (r_a[LIMB_W-1] == w_b_eff[LIMB_W-1]) &&
                (w_sum_limb[LIMB_W-1] != r_a[LIMB_W-1]);
    end
  end

  assign RSP_ZERO = r_zero;
  assign RSP_OVF  = r_ovf;
`endif

  assign RSP_VALID = (r_state == DONE);
  assign BUSY      = (r_state != IDLE);
  assign RSP_ID    = r_id;
  assign RSP_SUM   = r_sum;
  assign RSP_COUT  = r_cout;

endmodule

// File: tb/tb_ccu2_mp_sequencer.sv
// Scoreboard bench for ccu2_mp_sequencer: directed corner cases plus randomized contention.
// Flag outputs are checked when CCU2_SEQ_FLAGS_EN is defined.
module tb_ccu2_mp_sequencer;

  localparam int unsigned LIMB_W = 8;
  localparam int unsigned LIMBS  = 4;
  localparam int unsigned W      = LIMB_W * LIMBS;

  logic           CLK = 1'b0;
  logic           SRN;
  logic [1:0]     REQ_VALID, REQ_READY, REQ_SUB;
  logic [2*W-1:0] REQ_A, REQ_B;
  logic           RSP_VALID, RSP_READY, RSP_ID, RSP_COUT, BUSY;
  logic [W-1:0]   RSP_SUM;
`ifdef CCU2_SEQ_FLAGS_EN
  logic           RSP_ZERO, RSP_OVF;
`endif

  always #5 CLK = ~CLK;

  ccu2_mp_sequencer #(
    .LIMB_W (LIMB_W),
    .LIMBS  (LIMBS)
  ) dut (
    .CLK       (CLK),
    .SRN       (SRN),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_SUB   (REQ_SUB),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_SUM   (RSP_SUM),
    .RSP_COUT  (RSP_COUT),
`ifdef CCU2_SEQ_FLAGS_EN
    .RSP_ZERO  (RSP_ZERO),
    .RSP_OVF   (RSP_OVF),
`endif
    .BUSY      (BUSY)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from whole-word arithmetic.
  function automatic rsp_t ref_op(input logic id, input logic sub,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    logic [W:0] full;
    r.id = id;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    end
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Protocol model: idle/busy, fixed latency, round-robin grant.
  logic       m_busy = 1'b0;
  int         m_cnt  = 0;
  logic       m_last = 1'b1;
  logic       m_g;
  logic [1:0] m_rdy;

  always @(negedge CLK) begin
    if (!SRN) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_last = 1'b1;
      exp_q.delete();
    end else begin
      m_rdy = 2'b00;
      m_g   = 1'b0;
      if (!m_busy) begin
        if (REQ_VALID == 2'b11) m_g = ~m_last;
        else if (REQ_VALID == 2'b10) m_g = 1'b1;
        else m_g = 1'b0;
        if (REQ_VALID[m_g]) m_rdy[m_g] = 1'b1;
      end
      check("req_ready", 64'(REQ_READY), 64'(m_rdy));
      check("busy", 64'(BUSY), 64'(m_busy));
      check("rsp_valid", 64'(RSP_VALID), 64'(m_busy && (m_cnt >= int'(LIMBS))));
      if (m_busy) begin
        if (m_cnt >= int'(LIMBS)) begin
          if (RSP_READY) m_busy = 1'b0;
        end else begin
          m_cnt++;
        end
      end else if (m_rdy != 2'b00) begin
        exp_q.push_back(ref_op(m_g, REQ_SUB[m_g], REQ_A[m_g*W +: W], REQ_B[m_g*W +: W]));
        m_busy = 1'b1;
        m_cnt  = 0;
        m_last = m_g;
      end
    end
  end

  // Response monitor: compares the head entry while valid, pops on handshake.
  always @(negedge CLK) begin
    rsp_t e;
    if (SRN && RSP_VALID) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%0h, expected no response", RSP_ID,
                 RSP_SUM);
      end else begin
        e = exp_q[0];
        check("rsp_id", 64'(RSP_ID), 64'(e.id));
        check("rsp_sum", 64'(RSP_SUM), 64'(e.sum));
        check("rsp_cout", 64'(RSP_COUT), 64'(e.cout));
`ifdef CCU2_SEQ_FLAGS_EN
        check("rsp_zero", 64'(RSP_ZERO), 64'(e.zero));
        check("rsp_ovf", 64'(RSP_OVF), 64'(e.ovf));
`endif
        if (RSP_READY) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    RSP_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       RSP_READY = 1'b1;
        1:       RSP_READY = 1'($urandom_range(0, 1));
        default: RSP_READY = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h1;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic load(input int i, input logic sub, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    REQ_SUB[i]       = sub;
    REQ_A[i*W +: W]  = a;
    REQ_B[i*W +: W]  = b;
  endtask

  task automatic load_rand(input int i);
    load(i, 1'($urandom_range(0, 1)), pick_val(), pick_val());
  endtask

  // Holds requesters in mask valid until n accepts; reload keeps them busy with new ops.
  task automatic run_ops(input int n, input logic [1:0] mask, input bit reload);
    int cnt = 0;
    int guard = 0;
    logic [1:0] acc;
    for (int i = 0; i < 2; i++) if (reload && mask[i]) load_rand(i);
    REQ_VALID = mask;
    while (cnt < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
      acc = REQ_VALID & REQ_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          cnt++;
          if (reload && cnt < n) load_rand(i);
          else REQ_VALID[i] = 1'b0;
        end
      end
    end
    REQ_VALID = 2'b00;
    if (cnt < n) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got %0d accepts, expected %0d", cnt, n);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    if (BUSY) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got BUSY=1, expected 0");
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(REQ_READY), 64'(0));
    check({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'(0));
    check({tag, "_rsp_id"}, 64'(RSP_ID), 64'(0));
    check({tag, "_rsp_sum"}, 64'(RSP_SUM), 64'(0));
    check({tag, "_rsp_cout"}, 64'(RSP_COUT), 64'(0));
    check({tag, "_busy"}, 64'(BUSY), 64'(0));
  endtask

  initial begin
    int guard;
    SRN       = 1'b0;
    REQ_VALID = 2'b00;
    REQ_SUB   = 2'b00;
    REQ_A     = '0;
    REQ_B     = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    SRN = 1'b1;
    @(posedge CLK);
    #1;

    // Directed single operations, including wrap and borrow boundaries.
    load(0, 1'b0, 32'h0000_00FF, 32'h0000_0001); run_ops(1, 2'b01, 0); wait_idle();
    load(1, 1'b1, 32'h0, 32'h1);                 run_ops(1, 2'b10, 0); wait_idle();
    load(1, 1'b1, 32'h5, 32'h5);                 run_ops(1, 2'b10, 0); wait_idle();
    load(0, 1'b0, 32'hFFFF_FFFF, 32'h1);         run_ops(1, 2'b01, 0); wait_idle();
    load(0, 1'b0, 32'h7FFF_FFFF, 32'h1);         run_ops(1, 2'b01, 0); wait_idle();
    load(1, 1'b1, 32'h8000_0000, 32'h1);         run_ops(1, 2'b10, 0); wait_idle();

    // Contention: both held valid for six ops.
    run_ops(6, 2'b11, 1);
    wait_idle();

    // Backpressure: response held while the other requester knocks.
    rdy_mode = 2;
    load(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
    run_ops(1, 2'b01, 0);
    guard = 0;
    while (!RSP_VALID && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    load(1, 1'b1, 32'hAAAA_0000, 32'h0000_5555);
    REQ_VALID = 2'b10;
    repeat (10) @(posedge CLK);
    #1;
    check("bp_busy", 64'(BUSY), 64'(1));
    check("bp_req_ready", 64'(REQ_READY), 64'(0));
    check("bp_rsp_valid", 64'(RSP_VALID), 64'(1));
    REQ_VALID = 2'b00;
    rdy_mode  = 0;
    wait_idle();

    // Asynchronous reset in the middle of RUN, then a fresh op at full latency.
    load(1, 1'b0, 32'hDEAD_BEEF, 32'h0102_0304);
    run_ops(1, 2'b10, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    SRN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    @(posedge CLK);
    #1;
    SRN = 1'b1;
    load(0, 1'b0, 32'h1, 32'h1);
    run_ops(1, 2'b01, 0);
    wait_idle();

    // Randomized traffic with random response backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      run_ops(int'($urandom_range(1, 4)), 2'($urandom_range(1, 3)), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1;
    end
    rdy_mode = 0;
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
